lane_state_encoder: RTL

Converts per-lane vehicle arrival/departure pulses for intersections A and B into the packed 12-bit congestion states S_A and S_B consumed by the reward decider and the Q-table addressing logic. It keeps a saturating queue-occupancy counter per lane (8 counters in total). On a sample request it snapshots the counters, quantises each one to a 3-bit level and presents the two state words with a one-cycle valid strobe. It sits between the lane sensor front-end and the Q-learning agent. It is the producer side of the S_A/S_B interface.

---
 rtl/lane_state_encoder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lane_state_encoder.sv
// lane_state_encoder
// Tracks queue occupancy for four lanes at each of two intersections (A, B)
// with saturating up/down counters. On a sample request it snapshots all
// eight counters, quantises each to a 3-bit congestion level and presents
// the packed state words S_A / S_B with a one-cycle valid strobe.

module lane_state_encoder #(
    parameter int CNT_W = 8,
    parameter int SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arr_a,
    input  logic [3:0]  dep_a,
    input  logic [3:0]  arr_b,
    input  logic [3:0]  dep_b,
    input  logic        sample,
    output logic        busy,
    output logic [11:0] S_A,
    output logic [11:0] S_B,
    output logic        s_valid,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        QUANT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LVL_CAP  = CNT_W'(3'd7);

    // Level = count >> SHIFT, clamped to the largest 3-bit level.
    function automatic logic [2:0] quantise(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] sh;
        sh = v >> SHIFT;
        if (sh > LVL_CAP) begin
            quantise = 3'd7;
        end else begin
            quantise = 3'(sh);
        end
    endfunction

    // Lanes 0..3 are intersection A, lanes 4..7 are intersection B.
    logic [7:0]       arr_s;
    logic [7:0]       dep_s;
    logic [CNT_W-1:0] cnt_r     [8];
    logic [CNT_W-1:0] cnt_nxt_s [8];
    logic [CNT_W-1:0] snap_r    [8];
    logic             err_evt_s;
    logic             err_r;
    logic [11:0]      qa_s;
    logic [11:0]      qb_s;
    logic [11:0]      s_a_r;
    logic [11:0]      s_b_r;
    logic             s_valid_r;
    logic             busy_r;
    state_t           state_r;

    assign arr_s = {arr_b, arr_a};
    assign dep_s = {dep_b, dep_a};

    // Next counter values with saturation; flags any over/underflow attempt.
    always_comb begin
        err_evt_s = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cnt_nxt_s[k] = cnt_r[k];
            case ({arr_s[k], dep_s[k]})
                2'b10: begin
                    if (cnt_r[k] == CNT_MAX) begin
                        err_evt_s = 1'b1;
                    end else begin
                        cnt_nxt_s[k] = cnt_r[k] + CNT_ONE;
                    end
                end
                2'b01: begin
                    if (cnt_r[k] == CNT_ZERO) begin
                        err_evt_s = 1'b1;
                    end else begin
                        cnt_nxt_s[k] = cnt_r[k] - CNT_ONE;
                    end
                end
                default: begin
                    cnt_nxt_s[k] = cnt_r[k];
                end
            endcase
        end
    end

    // Occupancy counters update every cycle regardless of the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                cnt_r[k] <= CNT_ZERO;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                cnt_r[k] <= cnt_nxt_s[k];
            end
        end
    end

    // Sticky error flag, only cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (err_evt_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Quantise the snapshot into the packed state words.
    always_comb begin
        qa_s = 12'h000;
        qb_s = 12'h000;
        for (int i = 0; i < 4; i++) begin
            qa_s[3*i +: 3] = quantise(snap_r[i]);
            qb_s[3*i +: 3] = quantise(snap_r[i+4]);
        end
    end

    // Sample FSM: snapshot in IDLE, publish in QUANT, drop strobe in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            s_valid_r <= 1'b0;
            s_a_r     <= 12'h000;
            s_b_r     <= 12'h000;
            for (int k = 0; k < 8; k++) begin
                snap_r[k] <= CNT_ZERO;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    s_valid_r <= 1'b0;
                    if (sample) begin
                        // Pre-edge counts: same-cycle events land in the next snapshot.
                        for (int k = 0; k < 8; k++) begin
                            snap_r[k] <= cnt_r[k];
                        end
                        state_r <= QUANT;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                QUANT: begin
                    s_a_r     <= qa_s;
                    s_b_r     <= qb_s;
                    s_valid_r <= 1'b1;
                    busy_r    <= 1'b1;
                    state_r   <= DONE;
                end
                DONE: begin
                    s_valid_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    s_valid_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign S_A     = s_a_r;
    assign S_B     = s_b_r;
    assign s_valid = s_valid_r;
    assign err     = err_r;

endmodule
